// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch controller states (IDLE, RUN, HALT)
//   instr_word_t  : 9-bit instruction word {format, opcode, sign, operand}
//   field slice constants and the default halt encoding
//   pack_word()   : assembles the ROM field bundle into an instruction word
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef logic [8:0] instr_word_t;

    localparam int FMT_BIT  = 8;
    localparam int OPC_HI   = 7;
    localparam int OPC_LO   = 4;
    localparam int SIGN_BIT = 3;
    localparam int OPD_HI   = 2;
    localparam int OPD_LO   = 0;

    localparam instr_word_t HALT_WORD_DEF = 9'h1B0;

    function automatic instr_word_t pack_word(input logic       fmt,
                                              input logic [3:0] opc,
                                              input logic       sgn,
                                              input logic [2:0] opd);
        instr_word_t w;
        w                 = '0;
        w[FMT_BIT]        = fmt;
        w[OPC_HI:OPC_LO]  = opc;
        w[SIGN_BIT]       = sgn;
        w[OPD_HI:OPD_LO]  = opd;
        return w;
    endfunction

endpackage

// File: rtl/fetch_ir_reg.sv
// ---------------------------------------------------------------------------
// fetch_ir_reg
// One-entry instruction register with valid flag and flush.
//   clk, reset : clock / synchronous active-high reset
//   load       : capture word_p0 / pc_p0 and mark valid
//   flush      : drop the valid flag (contents are kept); wins over load
//   word_p0    : instruction word from the ROM
//   pc_p0      : address the word came from
//   vld_p1     : register holds a valid instruction
//   word_p1    : held instruction word
//   pc_p1      : address of the held word
// ---------------------------------------------------------------------------
module fetch_ir_reg
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                flush,
    input  instr_word_t         word_p0,
    input  logic [PC_WIDTH-1:0] pc_p0,
    output logic                vld_p1,
    output instr_word_t         word_p1,
    output logic [PC_WIDTH-1:0] pc_p1
);

    // p0 -> p1: ROM word captured into the instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            word_p1 <= '0;
            pc_p1   <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            word_p1 <= word_p0;
            pc_p1   <= pc_p0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Reader side of the combinational instruction ROM. Drives the PC to the
// ROM, reassembles the returned fields into a 9-bit word, holds it in a
// one-entry IR and hands it to decode with valid/ready. Handles branch
// redirect, stall, and halt detection.
//
// Ports:
//   clk, reset          : clock / synchronous active-high reset
//   start               : leave IDLE and begin fetching (IDLE only)
//   rom_pc              : ROM address (the internal PC)
//   rom_format/opcode/sign/operand : ROM word fields
//   branch_en/target    : redirect request from execute
//   instr_ready         : decoder accepts the IR this cycle
//   instr_valid/out/pc  : IR contents presented to decode
//   halted              : halt word accepted, fetch stopped (sticky)
//   fetch_count         : accepted instructions, saturating
//   bound_err           : PC left the program range (optional feature)
//
// Build option: define FETCH_BOUND_CHECK_EN to stop fetch with bound_err
// when a load is attempted at PC >= PROG_LEN. Without it, bound_err is 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    PC_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter instr_word_t           HALT_WORD = HALT_WORD_DEF,
    parameter logic [PC_WIDTH-1:0]   PROG_LEN  = PC_WIDTH'(120)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [PC_WIDTH-1:0] rom_pc,
    input  logic                rom_format,
    input  logic [3:0]          rom_opcode,
    input  logic                rom_sign,
    input  logic [2:0]          rom_operand,
    input  logic                branch_en,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                instr_ready,
    output logic                instr_valid,
    output instr_word_t         instr_out,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                halted,
    output logic [15:0]         fetch_count,
    output logic                bound_err
);

`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND_CHECK = 1'b1;
`else
    localparam bit BOUND_CHECK = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    instr_word_t         word_p0;
    logic                ir_load, ir_flush;
    logic                halt_set, bnd_set;
    logic                halt_pending, transfer, pc_oob;
    logic                bound_err_q;

    assign rom_pc       = pc;
    assign word_p0      = pack_word(rom_format, rom_opcode, rom_sign, rom_operand);
    assign halt_pending = instr_valid && (instr_out == HALT_WORD);
    assign transfer     = (state == RUN) && instr_valid && instr_ready;
    assign pc_oob       = BOUND_CHECK && (pc >= PROG_LEN);
    assign bound_err    = bound_err_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Branch outranks everything; a pending halt word blocks further loads
    // until it is either accepted or flushed by a branch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_load    = 1'b0;
        ir_flush   = 1'b0;
        halt_set   = 1'b0;
        bnd_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (branch_en) begin
                    pc_next  = branch_target;
                    ir_flush = 1'b1;
                end else if (halt_pending) begin
                    if (instr_ready) begin
                        ir_flush   = 1'b1;
                        halt_set   = 1'b1;
                        state_next = HALT;
                    end
                end else if (!instr_valid || instr_ready) begin
                    if (pc_oob) begin
                        ir_flush   = 1'b1;
                        halt_set   = 1'b1;
                        bnd_set    = 1'b1;
                        state_next = HALT;
                    end else begin
                        ir_load = 1'b1;
                        pc_next = pc + PC_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fetch_count <= '0;
            bound_err_q <= 1'b0;
        end else begin
            pc <= pc_next;
            if (halt_set) halted      <= 1'b1;
            if (bnd_set)  bound_err_q <= 1'b1;
            if (transfer) fetch_count <= sat_inc(fetch_count);
        end
    end

    fetch_ir_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_ir (
        .clk     (clk),
        .reset   (reset),
        .load    (ir_load),
        .flush   (ir_flush),
        .word_p0 (word_p0),
        .pc_p0   (pc),
        .vld_p1  (instr_valid),
        .word_p1 (instr_out),
        .pc_p1   (instr_pc)
    );

endmodule
